binop_result_checker: RTL and testbench
=======================================

BINOP_RESULT_CHECKER -- requirements
Module: binop_result_checker

Interface
- REQ-001: Parameter WIDTH, default 4, sets the result width in bits; legal range 1..64.
- REQ-002: Parameter CNTW, default 16, sets the width of every counter and index.
- REQ-003: clk  input  1  sole clock; all state SHALL update on its rising edge.
- REQ-004: rst  input  1  reset, asynchronous and active-high.
- REQ-005: chk  input  1  compare strobe from the stimulus driver; a 0->1 transition requests one comparison.
- REQ-006: spec_upper, spec_lower  input  WIDTH each  spec result, 4vec encoded per bit: 0=(0,0), 1=(1,1), X=(1,0), Z=(0,1).
- REQ-007: impl_upper, impl_lower  input  WIDTH each  implementation result, same 4vec encoding.
- REQ-008: clear  input  1  synchronous clear of counters, first-error record and halt.
- REQ-009: stop_on_err  input  1  when high, the first mismatch halts checking.
- REQ-010: vec_count  output  CNTW  number of comparisons performed.
- REQ-011: err_count  output  CNTW  number of mismatching comparisons.
- REQ-012: err_pulse  output  1  one-cycle pulse per mismatch.
- REQ-013: first_err_valid  output  1  set when the first mismatch is recorded.
- REQ-014: first_err_index  output  CNTW  vec_count value at the first mismatch.
- REQ-015: first_err_spec_u, first_err_spec_l, first_err_impl_u, first_err_impl_l  output  WIDTH each  operands captured at the first mismatch.
- REQ-016: halted  output  1  high while in state HALTED.

Function
- REQ-017: The block SHALL register chk and detect a rising edge as chk=1 with chk_q=0.
- REQ-018: Edge cycle (stage 1): both operand pairs SHALL be sampled into capture registers.
- REQ-019: Next cycle (stage 2): the compare SHALL be evaluated. Mismatch means any bit whose (upper,lower) pair differs after normalization.
- REQ-020: Latency from a chk rising edge to err_pulse and counter update SHALL be exactly 2 cycles. Back-to-back edges one cycle apart SHALL both be counted; the path is fully pipelined.
- REQ-021: States are RUN and HALTED.
  - RUN -> HALTED when a stage-2 mismatch occurs with stop_on_err=1.
  - HALTED -> RUN only on clear.
- REQ-022: In HALTED, chk edges SHALL be ignored. Comparisons already in stage 2 at the halting cycle SHALL complete.
- REQ-023: vec_count SHALL increment by 1 per stage-2 compare. err_count SHALL increment by 1 per mismatch. Both SHALL saturate at 2^CNTW-1 with no wrap.
- REQ-024: The first-error record SHALL load only when first_err_valid=0. Once loaded it SHALL hold until clear or rst.
- REQ-025: If clear and a stage-2 compare occur in the same cycle, clear SHALL win: the stage-2 compare is discarded and the pipeline is flushed.
- REQ-026: An edge during clear SHALL be dropped.

Reset
- REQ-027: On rst, the following SHALL be 0 and state SHALL be RUN, immediately and asynchronously: vec_count, err_count, err_pulse, first_err_valid, first_err_index, all first_err_* vectors, halted, chk_q and the pipeline valid bits.
- REQ-028: Asserting rst mid-pipeline SHALL discard in-flight comparisons; no count or pulse results from them after release.

Configuration
- REQ-029: Macro BINOP_CHECKER_Z_AS_X_EN.
  - Defined: every Z (0,1) bit in both spec and impl SHALL be normalized to X (1,0) before compare, so Z vs X is a match.
  - Undefined: the compare SHALL be exact 4-valued identity, so Z vs X is a mismatch.
  - Captured first_err_* values are pre-normalization in both builds.

Verification
- REQ-030: rst, then a chk edge with spec=impl=4'b10X0 -> vec_count=1, err_count=0, err_pulse never high.
- REQ-031: chk edge with spec=4'b0001, impl=4'b0000 -> err_pulse high exactly 2 cycles after the edge; first_err_valid=1; first_err_index=0; err_count=1.
- REQ-032: spec bit0=X, impl bit0=Z, other bits equal -> with BINOP_CHECKER_Z_AS_X_EN: err_count=0; without it: err_count=1.
- REQ-033: stop_on_err=1, mismatch on vector 3 of 6 consecutive chk edges -> halted=1, vec_count=3 (plus any vector already in stage 2), later edges ignored; after clear, halted=0 and counts=0.
- REQ-034: CNTW=4 with 20 mismatching edges -> vec_count=15, err_count=15 (saturated); first_err_index=0.
- REQ-035: rst asserted the cycle after a mismatching chk edge -> after release, err_count=0, vec_count=0 and no err_pulse.

Source files
------------

// File: rtl/binop_result_checker.sv
// rtl/binop_result_checker.sv - pipelined 4-valued result checker with counters and first-error capture
//
// Compares a spec result against an implementation result, both 4vec encoded
// per bit as (upper,lower): 0=(0,0), 1=(1,1), X=(1,0), Z=(0,1).
// A rising edge on chk is captured in stage 1 and compared in stage 2, so
// err_pulse and the counters move exactly 2 cycles after the edge cycle.
//
// Optional build macro: BINOP_CHECKER_Z_AS_X_EN
//   defined   - Z bits are normalized to X on both sides before comparing
//   undefined - exact 4-valued identity compare
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   chk                           compare strobe (rising edge requests one compare)
//   spec_upper/spec_lower         spec result (WIDTH each)
//   impl_upper/impl_lower         implementation result (WIDTH each)
//   clear                         synchronous clear of counters, first-error record, halt
//   stop_on_err                   halt checking on a mismatch
//   vec_count, err_count          saturating compare / mismatch counters (CNTW)
//   err_pulse                     one-cycle pulse per mismatch
//   first_err_valid/index         first mismatch record and its vec_count value
//   first_err_spec_u/l, impl_u/l  raw operands of the first mismatch
//   halted                        high while checking is halted

module binop_result_checker #(
   parameter int WIDTH = 4,
   parameter int CNTW  = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             chk,
   input  logic [WIDTH-1:0] spec_upper,
   input  logic [WIDTH-1:0] spec_lower,
   input  logic [WIDTH-1:0] impl_upper,
   input  logic [WIDTH-1:0] impl_lower,
   input  logic             clear,
   input  logic             stop_on_err,
   output logic [CNTW-1:0]  vec_count,
   output logic [CNTW-1:0]  err_count,
   output logic             err_pulse,
   output logic             first_err_valid,
   output logic [CNTW-1:0]  first_err_index,
   output logic [WIDTH-1:0] first_err_spec_u,
   output logic [WIDTH-1:0] first_err_spec_l,
   output logic [WIDTH-1:0] first_err_impl_u,
   output logic [WIDTH-1:0] first_err_impl_l,
   output logic             halted
);

   typedef enum logic {
      RUN    = 1'b0,
      HALTED = 1'b1
   } state_t;

   localparam logic [CNTW-1:0] CNT_MAX = '1;

   state_t           state_q, state_d;
   logic             chk_q;
   logic             cap_valid;
   logic [WIDTH-1:0] cap_su, cap_sl, cap_iu, cap_il;

   logic             chk_edge;
   logic             capture;
   logic             mismatch;
   logic [WIDTH-1:0] spec_z, impl_z;
   logic [WIDTH-1:0] su_n, sl_n, iu_n, il_n;

   assign chk_edge = chk & ~chk_q;
   // Edges are dropped while halted or while clear is asserted.
   assign capture  = chk_edge & ~clear & (state_q == RUN);

`ifdef BINOP_CHECKER_Z_AS_X_EN
   // A Z bit is (upper,lower)=(0,1); rewrite it to X=(1,0).
   assign spec_z = ~cap_su & cap_sl;
   assign impl_z = ~cap_iu & cap_il;
`else
   assign spec_z = '0;
   assign impl_z = '0;
`endif

   assign su_n = cap_su | spec_z;
   assign sl_n = cap_sl & ~spec_z;
   assign iu_n = cap_iu | impl_z;
   assign il_n = cap_il & ~impl_z;

   assign mismatch = |((su_n ^ iu_n) | (sl_n ^ il_n));

   assign halted = (state_q == HALTED);

   always_comb begin
      state_d = state_q;
      if (clear) begin
         state_d = RUN;
      end else if (state_q == RUN && cap_valid && mismatch && stop_on_err) begin
         state_d = HALTED;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= RUN;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         chk_q            <= 1'b0;
         cap_valid        <= 1'b0;
         cap_su           <= '0;
         cap_sl           <= '0;
         cap_iu           <= '0;
         cap_il           <= '0;
         vec_count        <= '0;
         err_count        <= '0;
         err_pulse        <= 1'b0;
         first_err_valid  <= 1'b0;
         first_err_index  <= '0;
         first_err_spec_u <= '0;
         first_err_spec_l <= '0;
         first_err_impl_u <= '0;
         first_err_impl_l <= '0;
      end else begin
         chk_q     <= chk;
         cap_valid <= capture;
         err_pulse <= 1'b0;
         if (capture) begin
            cap_su <= spec_upper;
            cap_sl <= spec_lower;
            cap_iu <= impl_upper;
            cap_il <= impl_lower;
         end
         // Clear takes priority over a stage-2 compare in the same cycle.
         if (clear) begin
            vec_count        <= '0;
            err_count        <= '0;
            first_err_valid  <= 1'b0;
            first_err_index  <= '0;
            first_err_spec_u <= '0;
            first_err_spec_l <= '0;
            first_err_impl_u <= '0;
            first_err_impl_l <= '0;
         end else if (cap_valid) begin
            if (vec_count != CNT_MAX) begin
               vec_count <= vec_count + CNTW'(1);
            end
            if (mismatch) begin
               err_pulse <= 1'b1;
               if (err_count != CNT_MAX) begin
                  err_count <= err_count + CNTW'(1);
               end
               if (!first_err_valid) begin
                  // Index is the count of compares before this one.
                  first_err_valid  <= 1'b1;
                  first_err_index  <= vec_count;
                  first_err_spec_u <= cap_su;
                  first_err_spec_l <= cap_sl;
                  first_err_impl_u <= cap_iu;
                  first_err_impl_l <= cap_il;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_binop_result_checker.sv
// tb/tb_binop_result_checker.sv - self-checking bench for binop_result_checker
module tb_binop_result_checker;

   localparam int WIDTH = 4;
   localparam int CNTW  = 4;
   localparam int MAXC  = 15;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             chk = 1'b0;
   logic [WIDTH-1:0] spec_upper = '0, spec_lower = '0, impl_upper = '0, impl_lower = '0;
   logic             clear = 1'b0;
   logic             stop_on_err = 1'b0;
   logic [CNTW-1:0]  vec_count, err_count, first_err_index;
   logic             err_pulse, first_err_valid, halted;
   logic [WIDTH-1:0] first_err_spec_u, first_err_spec_l, first_err_impl_u, first_err_impl_l;

   binop_result_checker #(.WIDTH(WIDTH), .CNTW(CNTW)) dut (
      .clk(clk), .rst(rst), .chk(chk),
      .spec_upper(spec_upper), .spec_lower(spec_lower),
      .impl_upper(impl_upper), .impl_lower(impl_lower),
      .clear(clear), .stop_on_err(stop_on_err),
      .vec_count(vec_count), .err_count(err_count), .err_pulse(err_pulse),
      .first_err_valid(first_err_valid), .first_err_index(first_err_index),
      .first_err_spec_u(first_err_spec_u), .first_err_spec_l(first_err_spec_l),
      .first_err_impl_u(first_err_impl_u), .first_err_impl_l(first_err_impl_l),
      .halted(halted)
   );

   always #5 clk = ~clk;

   typedef struct {
      int due;
      bit mis;
   } exp_t;

   exp_t exp_q[$];
   exp_t e;
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;
   int   exp_vec = 0;
   int   exp_err = 0;
   bit   mon_en = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic bit model_mis(input logic [3:0] su, sl, iu, il);
      logic [3:0] a, b, c, d;
      a = su; b = sl; c = iu; d = il;
`ifdef BINOP_CHECKER_Z_AS_X_EN
      for (int i = 0; i < 4; i++) begin
         if (a[i] == 1'b0 && b[i] == 1'b1) begin a[i] = 1'b1; b[i] = 1'b0; end
         if (c[i] == 1'b0 && d[i] == 1'b1) begin c[i] = 1'b1; d[i] = 1'b0; end
      end
`endif
      return (a != c) || (b != d);
   endfunction

   // Scoreboard: pops the expected result in the cycle the DUT must report it.
   always @(negedge clk) begin
      if (mon_en && !rst) begin
         if (exp_q.size() > 0 && exp_q[0].due < cyc) begin
            checks++; failures++;
            $display("FAIL sb_stale due=%0d now=%0d", exp_q[0].due, cyc);
            void'(exp_q.pop_front());
         end
         if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            e = exp_q.pop_front();
            checks++;
            if (err_pulse !== e.mis) begin
               failures++;
               $display("FAIL sb_err_pulse cyc=%0d got=%b exp=%b", cyc, err_pulse, e.mis);
            end
            if (exp_vec < MAXC) exp_vec++;
            if (e.mis && exp_err < MAXC) exp_err++;
         end else begin
            checks++;
            if (err_pulse !== 1'b0) begin
               failures++;
               $display("FAIL sb_spurious_pulse cyc=%0d got=%b exp=0", cyc, err_pulse);
            end
         end
         checks++;
         if (vec_count !== CNTW'(exp_vec)) begin
            failures++;
            $display("FAIL sb_vec_count cyc=%0d got=%0d exp=%0d", cyc, vec_count, exp_vec);
         end
         checks++;
         if (err_count !== CNTW'(exp_err)) begin
            failures++;
            $display("FAIL sb_err_count cyc=%0d got=%0d exp=%0d", cyc, err_count, exp_err);
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   // Drives one chk edge (two cycles: high, low); queues the result if it must be counted.
   task automatic send(input logic [3:0] su, sl, iu, il, input bit counted);
      spec_upper = su; spec_lower = sl; impl_upper = iu; impl_lower = il;
      chk = 1'b1;
      if (counted) exp_q.push_back('{due: cyc + 2, mis: model_mis(su, sl, iu, il)});
      idle(1);
      chk = 1'b0;
      idle(1);
   endtask

   task automatic do_clear();
      mon_en = 1'b0;
      clear = 1'b1;
      idle(1);
      clear = 1'b0;
      exp_q.delete();
      exp_vec = 0;
      exp_err = 0;
      mon_en = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      #1 rst = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if ({vec_count, err_count, err_pulse, first_err_valid, first_err_index, halted} !== '0) begin
         failures++;
         $display("FAIL reset_state got=%0h exp=0",
                  {vec_count, err_count, err_pulse, first_err_valid, first_err_index, halted});
      end
      checks++;
      if ({first_err_spec_u, first_err_spec_l, first_err_impl_u, first_err_impl_l} !== '0) begin
         failures++;
         $display("FAIL reset_first_err got=%0h exp=0",
                  {first_err_spec_u, first_err_spec_l, first_err_impl_u, first_err_impl_l});
      end
      @(posedge clk); #1;
      rst = 1'b0;
      exp_q.delete(); exp_vec = 0; exp_err = 0;
      mon_en = 1'b1;
      idle(1);
   endtask

   task automatic test_match();
      send(4'b1010, 4'b1000, 4'b1010, 4'b1000, 1'b1);
      idle(3);
      checks++;
      if (vec_count !== 4'd1 || err_count !== 4'd0 || first_err_valid !== 1'b0) begin
         failures++;
         $display("FAIL match vec=%0d err=%0d fev=%b exp vec=1 err=0 fev=0",
                  vec_count, err_count, first_err_valid);
      end
   endtask

   task automatic test_mismatch();
      do_clear();
      send(4'b0001, 4'b0001, 4'b0000, 4'b0000, 1'b1);
      idle(3);
      checks++;
      if (err_count !== 4'd1 || first_err_valid !== 1'b1 || first_err_index !== 4'd0) begin
         failures++;
         $display("FAIL mismatch err=%0d fev=%b idx=%0d exp err=1 fev=1 idx=0",
                  err_count, first_err_valid, first_err_index);
      end
      checks++;
      if ({first_err_spec_u, first_err_spec_l, first_err_impl_u, first_err_impl_l} !== 16'h1100) begin
         failures++;
         $display("FAIL mismatch_capture got=%h exp=1100",
                  {first_err_spec_u, first_err_spec_l, first_err_impl_u, first_err_impl_l});
      end
   endtask

   task automatic test_z_as_x();
      logic [CNTW-1:0] exp_e;
`ifdef BINOP_CHECKER_Z_AS_X_EN
      exp_e = 4'd0;
`else
      exp_e = 4'd1;
`endif
      do_clear();
      // spec = 1,0,1,X  impl = 1,0,1,Z
      send(4'b1011, 4'b1010, 4'b1010, 4'b1011, 1'b1);
      idle(3);
      checks++;
      if (err_count !== exp_e) begin
         failures++;
         $display("FAIL z_as_x err=%0d exp=%0d", err_count, exp_e);
      end
      checks++;
      if (first_err_valid === 1'b1 && first_err_spec_l !== 4'b1010) begin
         failures++;
         $display("FAIL z_as_x_raw_capture got=%b exp=1010", first_err_spec_l);
      end
   endtask

   task automatic test_stop_on_err();
      do_clear();
      stop_on_err = 1'b1;
      for (int i = 1; i <= 6; i++) begin
         if (i == 3) send(4'b0110, 4'b0110, 4'b0111, 4'b0111, 1'b1);
         else        send(4'b0101, 4'b0100, 4'b0101, 4'b0100, i < 3);
      end
      idle(3);
      checks++;
      if (halted !== 1'b1 || vec_count !== 4'd3 || err_count !== 4'd1 || first_err_index !== 4'd2) begin
         failures++;
         $display("FAIL stop_on_err halted=%b vec=%0d err=%0d idx=%0d exp 1 3 1 2",
                  halted, vec_count, err_count, first_err_index);
      end
      stop_on_err = 1'b0;
      do_clear();
      @(negedge clk);
      checks++;
      if (halted !== 1'b0 || vec_count !== 4'd0 || err_count !== 4'd0 || first_err_valid !== 1'b0) begin
         failures++;
         $display("FAIL stop_clear halted=%b vec=%0d err=%0d fev=%b exp all 0",
                  halted, vec_count, err_count, first_err_valid);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back();
      logic [3:0] su, sl, iu, il, fsu, fsl, fiu, fil;
      bit found;
      int fidx;
      found = 1'b0; fidx = 0;
      fsu = '0; fsl = '0; fiu = '0; fil = '0;
      do_clear();
      for (int i = 0; i < 10; i++) begin
         su = 4'($urandom); sl = 4'($urandom);
         if ($urandom_range(0, 1) == 1) begin iu = su; il = sl; end
         else begin iu = 4'($urandom); il = 4'($urandom); end
         if (!found && model_mis(su, sl, iu, il)) begin
            found = 1'b1; fidx = i; fsu = su; fsl = sl; fiu = iu; fil = il;
         end
         send(su, sl, iu, il, 1'b1);
      end
      idle(3);
      checks++;
      if (vec_count !== 4'd10 || first_err_valid !== found) begin
         failures++;
         $display("FAIL b2b vec=%0d fev=%b exp vec=10 fev=%b", vec_count, first_err_valid, found);
      end
      if (found) begin
         checks++;
         if (first_err_index !== CNTW'(fidx) ||
             {first_err_spec_u, first_err_spec_l, first_err_impl_u, first_err_impl_l} !== {fsu, fsl, fiu, fil}) begin
            failures++;
            $display("FAIL b2b_first idx=%0d rec=%h exp idx=%0d rec=%h", first_err_index,
                     {first_err_spec_u, first_err_spec_l, first_err_impl_u, first_err_impl_l},
                     fidx, {fsu, fsl, fiu, fil});
         end
      end
   endtask

   task automatic test_saturation();
      do_clear();
      for (int i = 0; i < 20; i++) send(4'(i), 4'(i), ~4'(i), ~4'(i), 1'b1);
      idle(3);
      checks++;
      if (vec_count !== 4'd15 || err_count !== 4'd15 || first_err_index !== 4'd0) begin
         failures++;
         $display("FAIL saturation vec=%0d err=%0d idx=%0d exp 15 15 0",
                  vec_count, err_count, first_err_index);
      end
   endtask

   task automatic test_clear_wins();
      do_clear();
      mon_en = 1'b0;
      spec_upper = 4'b1111; spec_lower = 4'b1111; impl_upper = 4'b0000; impl_lower = 4'b0000;
      chk = 1'b1;
      idle(1);
      chk = 1'b0; clear = 1'b1;
      idle(1);
      clear = 1'b0;
      @(negedge clk);
      checks++;
      if (err_pulse !== 1'b0 || vec_count !== 4'd0 || err_count !== 4'd0 || first_err_valid !== 1'b0) begin
         failures++;
         $display("FAIL clear_wins pulse=%b vec=%0d err=%0d fev=%b exp all 0",
                  err_pulse, vec_count, err_count, first_err_valid);
      end
      @(posedge clk); #1;
      clear = 1'b1; chk = 1'b1;
      idle(1);
      clear = 1'b0; chk = 1'b0;
      idle(3);
      @(negedge clk);
      checks++;
      if (vec_count !== 4'd0 || err_count !== 4'd0) begin
         failures++;
         $display("FAIL edge_during_clear vec=%0d err=%0d exp 0 0", vec_count, err_count);
      end
      @(posedge clk); #1;
      do_clear();
   endtask

   task automatic test_reset_midpipe();
      do_clear();
      send(4'b0011, 4'b0011, 4'b0011, 4'b0011, 1'b1);
      idle(3);
      spec_upper = 4'b1100; spec_lower = 4'b1100; impl_upper = 4'b0011; impl_lower = 4'b0011;
      chk = 1'b1;
      idle(1);
      chk = 1'b0;
      rst = 1'b1;
      exp_q.delete(); exp_vec = 0; exp_err = 0;
      #1;
      checks++;
      if (vec_count !== 4'd0 || err_pulse !== 1'b0) begin
         failures++;
         $display("FAIL async_reset vec=%0d pulse=%b exp 0 0", vec_count, err_pulse);
      end
      idle(1);
      rst = 1'b0;
      idle(4);
      checks++;
      if (err_count !== 4'd0 || vec_count !== 4'd0 || first_err_valid !== 1'b0) begin
         failures++;
         $display("FAIL reset_midpipe err=%0d vec=%0d fev=%b exp 0 0 0",
                  err_count, vec_count, first_err_valid);
      end
   endtask

   initial begin
      test_reset();
      test_match();
      test_mismatch();
      test_z_as_x();
      test_stop_on_err();
      test_back_to_back();
      test_saturation();
      test_clear_wins();
      test_reset_midpipe();
      idle(2);
      mon_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
